// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// The slave modport is the loader's view; master is the surrounding environment.
interface imem_boot_loader_if #(
  parameter int data_width = 32
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  imem_we;
  logic [data_width-1:0] imem_addr;
  logic [data_width-1:0] imem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: packs a little-endian byte stream into instruction words,
// writes them to consecutive word addresses and holds the core in reset until
// the whole image has landed.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN adds a trailing checksum byte
// that must bring the modulo-256 sum of all data bytes to zero.
module imem_boot_loader #(
  parameter int                    data_width  = 32,
  parameter int                    depth_width = 10,
  parameter logic [data_width-1:0] base_addr   = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [depth_width:0] cfg_words,
  imem_boot_loader_if.slave    bus,
  output logic                 cpu_reset_n,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int BPW = data_width / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [depth_width:0] MAX_WORDS = {1'b1, {depth_width{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;

  state_t                state;
  logic [depth_width:0]  words;
  logic [depth_width:0]  word_idx;
  logic [BIW-1:0]        byte_idx;
  logic [data_width-1:0] shift_word;
  logic [data_width-1:0] next_word;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]            sum;
`endif

  // Current partial word with the incoming byte dropped into its lane.
  always_comb begin
    next_word = shift_word;
    next_word[8*byte_idx +: 8] = bus.byte_in;
  end

  // Loader state machine; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      words          <= '0;
      word_idx       <= '0;
      byte_idx       <= '0;
      shift_word     <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum            <= '0;
`endif
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_reset_n    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        LOAD: begin
          if (word_idx == words) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            state          <= CHECK;
            bus.byte_ready <= 1'b1;
`else
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            cpu_reset_n    <= 1'b1;
`endif
          end else if (bus.byte_valid && bus.byte_ready) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum        <= sum + bus.byte_in;
`endif
            shift_word <= next_word;
            if (byte_idx == BIW'(BPW - 1)) begin
              byte_idx       <= '0;
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= base_addr + (data_width'(word_idx) << 2);
              bus.imem_wdata <= next_word;
              word_idx       <= word_idx + 1'b1;
              if (word_idx + 1'b1 == words) bus.byte_ready <= 1'b0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        CHECK: begin
          if (bus.byte_valid && bus.byte_ready) begin
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            if (8'(sum + bus.byte_in) == 8'h00) begin
              state       <= DONE;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        IDLE, DONE, ERROR: begin
          if (start) begin
            words       <= cfg_words;
            word_idx    <= '0;
            byte_idx    <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum         <= '0;
`endif
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
            if (cfg_words == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else if (cfg_words > MAX_WORDS) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state          <= LOAD;
              busy           <= 1'b1;
              bus.byte_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed image loads with literal
// expectations plus randomized loads compared every cycle against a
// byte-count level reference model.
module tb_imem_boot_loader;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_CHECK = 2;
  localparam int P_DONE  = 3;
  localparam int P_ERROR = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] cfg_words = '0;
  logic        cpu_reset_n, busy, done, error;

  imem_boot_loader_if #(.data_width(32)) bus ();

  imem_boot_loader #(.data_width(32), .depth_width(10), .base_addr(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_words(cfg_words),
    .bus(bus), .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  logic [7:0]  tx_q[$];
  logic [31:0] dut_wr_addr[$];
  logic [31:0] dut_wr_data[$];
  logic [31:0] m_wr_data[$];

  // Reference model: tracks accepted bytes and the load phase
  int          m_phase = P_IDLE;
  int          m_total = 0;
  int          m_got = 0;
  int          m_sum = 0;
  logic [7:0]  m_acc[$];
  bit          e_ready = 1'b0;
  bit          e_we = 1'b0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_wdata = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge, and immediately on reset
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = P_IDLE;
      m_acc.delete();
      e_ready = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    end else begin
      e_we = 0;
      if (m_phase == P_LOAD) begin
        if (m_got == m_total * 4) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          m_phase = P_CHECK;
          e_ready = 1;
`else
          m_phase = P_DONE;
`endif
        end else if (bus.byte_valid && e_ready) begin
          m_got++;
          m_sum = (m_sum + int'(bus.byte_in)) % 256;
          m_acc.push_back(bus.byte_in);
          if (m_acc.size() == 4) begin
            e_we    = 1;
            e_addr  = 32'(4 * (m_got / 4 - 1));
            e_wdata = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
            m_wr_data.push_back(e_wdata);
            m_acc.delete();
          end
          if (m_got == m_total * 4) e_ready = 0;
        end
      end else if (m_phase == P_CHECK) begin
        if (bus.byte_valid && e_ready) begin
          e_ready = 0;
          m_phase = ((m_sum + int'(bus.byte_in)) % 256 == 0) ? P_DONE : P_ERROR;
        end
      end else if (start) begin
        m_acc.delete();
        m_got = 0;
        m_sum = 0;
        if (cfg_words == 0) m_phase = P_DONE;
        else if (cfg_words > 11'd1024) m_phase = P_ERROR;
        else begin
          m_phase = P_LOAD;
          m_total = int'(cfg_words);
          e_ready = 1;
        end
      end
    end
  end

  // Compare process: logs DUT writes and checks every output each cycle
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      dut_wr_addr.push_back(bus.imem_addr);
      dut_wr_data.push_back(bus.imem_wdata);
    end
    if (check_en) begin
      check_output("byte_ready", 32'(bus.byte_ready), 32'(e_ready));
      check_output("imem_we", 32'(bus.imem_we), 32'(e_we));
      check_output("imem_addr", bus.imem_addr, e_addr);
      check_output("imem_wdata", bus.imem_wdata, e_wdata);
      check_output("busy", 32'(busy), 32'(m_phase == P_LOAD || m_phase == P_CHECK));
      check_output("done", 32'(done), 32'(m_phase == P_DONE));
      check_output("error", 32'(error), 32'(m_phase == P_ERROR));
      check_output("cpu_reset_n", 32'(cpu_reset_n), 32'(m_phase == P_DONE));
    end
  end

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [10:0] c);
    start = 1'b1;
    cfg_words = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // vmode: 0 valid always, 1 alternating, 2 random; glitch adds stray start pulses
  task automatic apply_stimulus(input int vmode, input bit glitch);
    int i = 0;
    int budget = 0;
    logic rdy;
    while (i < tx_q.size() && budget < 400) begin
      case (vmode)
        0:       bus.byte_valid = 1'b1;
        1:       bus.byte_valid = (budget % 2 == 0);
        default: bus.byte_valid = ($urandom_range(99) < 60);
      endcase
      bus.byte_in = tx_q[i];
      start = glitch && ($urandom_range(7) == 0);
      cfg_words = 11'($urandom_range(2047));
      @(negedge clk);
      rdy = bus.byte_ready;
      @(posedge clk);
      #1;
      if (bus.byte_valid && rdy) i++;
      budget++;
    end
    bus.byte_valid = 1'b0;
    start = 1'b0;
    if (i < tx_q.size()) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL send_timeout: sent %0d bytes required %0d", i, tx_q.size());
    end
  endtask

  task automatic load_example_image();
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_BOOT_CHECKSUM_EN
    tx_q.push_back(8'hFA);
`endif
  endtask

  task automatic check_example_writes(input string tag);
    check_output({tag, "_wr_count"}, 32'(dut_wr_data.size()), 32'd2);
    if (dut_wr_data.size() == 2) begin
      check_output({tag, "_addr0"}, dut_wr_addr[0], 32'h0);
      check_output({tag, "_data0"}, dut_wr_data[0], 32'h00500013);
      check_output({tag, "_addr1"}, dut_wr_addr[1], 32'h4);
      check_output({tag, "_data1"}, dut_wr_data[1], 32'h00100093);
    end
    check_output({tag, "_done"}, 32'(done), 32'd1);
    check_output({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    check_output("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check_output("rst_imem_addr", bus.imem_addr, 32'd0);
    check_output("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    check_en = 1'b1;
    idle(2);

    // Two-word image, valid held high
    dut_wr_addr.delete(); dut_wr_data.delete(); m_wr_data.delete();
    start_load(11'd2);
    load_example_image();
    apply_stimulus(0, 1'b0);
    idle(3);
    check_example_writes("img");
    check_output("model_data0", m_wr_data.size() > 0 ? m_wr_data[0] : 32'hDEAD, 32'h00500013);
    check_output("model_data1", m_wr_data.size() > 1 ? m_wr_data[1] : 32'hDEAD, 32'h00100093);

    // Same image with valid toggling
    dut_wr_addr.delete(); dut_wr_data.delete();
    start_load(11'd2);
    load_example_image();
    apply_stimulus(1, 1'b0);
    idle(3);
    check_example_writes("toggle");

    // Reset after 5 bytes of a 4-word load
    dut_wr_addr.delete(); dut_wr_data.delete();
    start_load(11'd4);
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    apply_stimulus(0, 1'b0);
    reset = 1'b0;
    #1;
    check_output("abort_byte_ready", 32'(bus.byte_ready), 32'd0);
    check_output("abort_imem_addr", bus.imem_addr, 32'd0);
    check_output("abort_imem_wdata", bus.imem_wdata, 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    idle(3);
    check_output("abort_wr_count", 32'(dut_wr_data.size()), 32'd1);
    reset = 1'b1;
    idle(1);
    dut_wr_addr.delete(); dut_wr_data.delete();
    start_load(11'd2);
    load_example_image();
    apply_stimulus(0, 1'b0);
    idle(3);
    check_example_writes("reload");

    // Oversize then zero-length image
    dut_wr_addr.delete(); dut_wr_data.delete();
    start_load(11'd1025);
    check_output("oversize_error", 32'(error), 32'd1);
    check_output("oversize_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    idle(2);
    check_output("oversize_wr_count", 32'(dut_wr_data.size()), 32'd0);
    start_load(11'd0);
    check_output("zero_done", 32'(done), 32'd1);
    check_output("zero_error", 32'(error), 32'd0);
    idle(2);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum trailer good and bad
    start_load(11'd1);
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h9D};
    apply_stimulus(0, 1'b0);
    idle(1);
    check_output("csum_ok_done", 32'(done), 32'd1);
    start_load(11'd1);
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h9C};
    apply_stimulus(0, 1'b0);
    idle(1);
    check_output("csum_bad_error", 32'(error), 32'd1);
    check_output("csum_bad_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    idle(2);
`endif

    // Randomized loads checked every cycle by the model
    for (int it = 0; it < 40; it++) begin
      int kind;
      int nw;
      int s;
      kind = $urandom_range(9);
      if (kind == 0) begin
        start_load(11'(1025 + $urandom_range(1022)));
      end else if (kind == 1) begin
        start_load(11'd0);
      end else begin
        nw = $urandom_range(1, 4);
        s = 0;
        tx_q.delete();
        for (int b = 0; b < nw * 4; b++) begin
          tx_q.push_back(8'($urandom_range(255)));
          s += int'(tx_q[b]);
        end
        start_load(11'(nw));
        if (kind == 9) begin
          while (tx_q.size() > nw * 2) void'(tx_q.pop_back());
          apply_stimulus(2, 1'b1);
          reset = 1'b0;
          idle(2);
          reset = 1'b1;
        end else begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          if ($urandom_range(1) == 0) tx_q.push_back(8'((256 - (s % 256)) % 256));
          else tx_q.push_back(8'($urandom_range(255)));
`endif
          apply_stimulus(int'($urandom_range(2)), 1'b1);
        end
      end
      idle(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
